// File: rtl/sipo_deser.sv
// sipo_deser: LSB-first serial-in/parallel-out deserializer with a one-word valid/ready holding register.
// Define PARITY_SIPO_EN to append an even-parity bit to every frame.
module sipo_deser #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  output logic                  parity_err
);
`ifdef PARITY_SIPO_EN
  localparam int FRAME = DATA_WIDTH + 1;
`else
  localparam int FRAME = DATA_WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  logic [DATA_WIDTH-1:0] sr, sr_nxt, word;
  logic [CW-1:0] cnt;
  logic accept, last, par_ok, done, free;
  always_comb begin
    accept = din_valid && !flush;
    last   = accept && cnt == CW'(FRAME - 1);
    free   = !dout_valid || dout_ready;
`ifdef PARITY_SIPO_EN
    // the parity bit is checked against sr but never shifted into it
    sr_nxt = (accept && cnt != CW'(DATA_WIDTH)) ? {din, sr[DATA_WIDTH-1:1]} : sr;
    word   = sr;
    par_ok = ~(^sr ^ din);
`else
    sr_nxt = accept ? {din, sr[DATA_WIDTH-1:1]} : sr;
    word   = sr_nxt;
    par_ok = 1'b1;
`endif
    done = last && par_ok;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr         <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      sr         <= sr_nxt;
      cnt        <= (flush || last) ? '0 : accept ? cnt + CW'(1) : cnt;
      overflow   <= done && !free;
      parity_err <= last && !par_ok;
      if (done && free) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule
